dna_frame_tx: RTL and testbench
===============================

// Module: dna_frame_tx
// PURPOSE
// - Consumes the 57-bit device DNA from the DNA capture stage (dna_data/dna_valid).
// - Packs it into a byte frame and presents the frame on a valid/ready byte stream for the UART TX.
// - One frame is emitted per capture event, letting the host read the TDC board's silicon ID.
// PARAMETERS
// - HDR_BYTE      8'hA5     first byte of every frame
// - EXPECTED_DNA  57'h0     reference ID, used only when DNA_CMP_EN is defined
// PORTS
// - sys_clk     in   1   system clock; all logic is on its rising edge
// - sys_rst     in   1   synchronous reset, active-high
// - dna_valid   in   1   from capture stage; level, held high once dna_data is stable
// - dna_data    in   57  device DNA, bit 56 = MSB
// - tx_data     out  8   frame byte
// - tx_valid    out  1   tx_data is valid
// - tx_ready    in   1   consumer accepts the byte
// - busy        out  1   high from capture through the last byte accepted
// - frame_done  out  1   1-cycle pulse, the cycle after the checksum byte is accepted
// - dna_match   out  1   only with DNA_CMP_EN defined; see CONFIGURATION
// BEHAVIOUR
// - Reset values: tx_data=0, tx_valid=0, busy=0, frame_done=0, dna_match=0; FSM=IDLE; edge reg=0.
// - Trigger:
//   - Rising edge of dna_valid (dna_valid & ~dna_valid_q) while in IDLE.
//   - dna_data is latched zero-extended to 64 bits in that same cycle.
//   - A constant-high dna_valid does not retrigger.
//   - Edges outside IDLE are ignored, not queued.
// - FSM states: IDLE -> HDR -> DATA -> (STAT) -> CSUM -> IDLE.
//   - IDLE->HDR on trigger.
//   - HDR->DATA when the header byte is accepted.
//   - DATA sends 8 bytes MSB-first using a 3-bit index; it leaves after index 7 is accepted.
//   - STAT exists only with DNA_CMP_EN.
//   - CSUM->IDLE when the checksum byte is accepted; frame_done pulses on the following cycle.
// - Latency: tx_valid rises 1 cycle after the trigger cycle. busy rises in that same cycle.
// - Handshake:
//   - A transfer occurs only when tx_valid & tx_ready.
//   - tx_data stays stable while tx_valid=1 and tx_ready=0.
//   - tx_valid never drops before its byte is accepted.
//   - With tx_ready held high: back-to-back bytes, 1 byte/cycle.
// - Checksum:
//   - 8-bit sum modulo 256 of all bytes after the header (data bytes, plus the status byte if present).
//   - Accumulated as each byte is accepted; cleared on trigger.
//   - Carries are discarded (wrap-around).
// - Reset mid-frame:
//   - Next cycle: FSM=IDLE, tx_valid=0, busy=0; the partial frame is abandoned.
//   - Edge reg is cleared, so a dna_valid still high after reset triggers a fresh frame.
// - If dna_valid falls mid-frame, the latched copy is used and the frame completes unchanged.
// CONFIGURATION
// - DNA_CMP_EN defined:
//   - The trigger cycle registers dna_match = (dna_data == EXPECTED_DNA).
//   - dna_match holds until the next trigger or reset.
//   - Frame = 11 bytes: HDR, 8 data, status (8'h01 match / 8'h00 mismatch), checksum.
// - DNA_CMP_EN undefined: no dna_match port, no comparator; frame = 10 bytes: HDR, 8 data, checksum.
// STRUCTURE
// - Package dna_pkg holds: DNA_W=57, FRAME_DATA_BYTES=8, the state enum (IDLE, HDR, DATA, STAT, CSUM), and STAT_MATCH/STAT_MISMATCH.
// - Sub-module dna_edge_det: 1-bit rising-edge detector with sync reset; is used for the trigger.
// - Byte mux, checksum accumulator and FSM are kept in this module.
// TESTING
// - 1: DNA=57'h0_0123_4567_89AB_CDEF, tx_ready=1, no macro.
//   - Bytes A5 01 23 45 67 89 AB CD EF C0 on 10 consecutive cycles.
//   - frame_done pulses once; busy then drops.
// - 2: Same DNA, tx_ready toggling 1/0 each cycle.
//   - Same 10 bytes; tx_data stable during stalls; frame takes 19 cycles.
// - 3: dna_valid held high 200 cycles after frame 1.
//   - Exactly one frame; a second low->high pulse sends a second identical frame.
// - 4: sys_rst asserted during DATA index 3 while dna_valid stays high.
//   - tx_valid=0 the next cycle; a new full frame starts with A5 after reset deasserts.
// - 5: DNA_CMP_EN, EXPECTED_DNA equal to the DNA of test 1.
//   - Frame ends ... EF 01 C1 and dna_match=1.
//   - Changing the DNA LSB gives status 00, dna_match=0, and a recomputed checksum.
// - 6: DNA=57'h1FF_FFFF_FFFF_FFFF (all ones).
//   - Data bytes 01 FF FF FF FF FF FF FF; checksum 0xFA (wrap-around check).

Source files
------------

// File: rtl/dna_pkg.sv
// Shared types and constants for the DNA frame transmitter.
package dna_pkg;

  localparam int unsigned DNA_W            = 57;
  localparam int unsigned FRAME_DATA_BYTES = 8;

  localparam logic [7:0] STAT_MATCH    = 8'h01;
  localparam logic [7:0] STAT_MISMATCH = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    STAT,
    CSUM
  } tx_state_t;

  // Byte idx of a 64-bit word, idx 0 being the most significant byte.
  function automatic logic [7:0] frame_byte(input logic [63:0] w, input logic [2:0] idx);
    logic [63:0] s;
    s = w >> {3'd7 - idx, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/dna_frame_tx_if.sv
// Valid/ready byte stream between the DNA frame transmitter and the UART TX.
interface dna_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dna_edge_det.sv
// Single-bit rising-edge detector with synchronous active-high reset.
module dna_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Delayed copy of the input; cleared by reset so a level held high
  // across reset is seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/dna_frame_tx.sv
// Packs the 57-bit device DNA into a byte frame on a valid/ready stream:
// HDR, 8 data bytes MSB-first, [status], checksum.
// Optional feature macro: DNA_CMP_EN (adds EXPECTED_DNA comparison,
// the dna_match port and a status byte before the checksum).
module dna_frame_tx
  import dna_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = 8'hA5
`ifdef DNA_CMP_EN
  ,
  parameter logic [DNA_W-1:0] EXPECTED_DNA = '0
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             dna_valid,
  input  logic [DNA_W-1:0] dna_data,
  dna_frame_tx_if.master   tx,
  output logic             busy,
  output logic             frame_done
`ifdef DNA_CMP_EN
  ,
  output logic             dna_match
`endif
);

  tx_state_t   state;
  logic [63:0] dna_q;
  logic [2:0]  idx;
  logic [7:0]  csum;
  logic [7:0]  csum_next;
  logic        trig_edge;

  dna_edge_det u_edge (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .d    (dna_valid),
    .rise (trig_edge)
  );

  // Running checksum including the byte currently being accepted.
  assign csum_next = csum + tx.tx_data;

  // Frame sequencer: byte mux, checksum accumulation and handshake outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      dna_q       <= '0;
      idx         <= '0;
      csum        <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef DNA_CMP_EN
      dna_match   <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_edge) begin
            dna_q       <= {{(64 - DNA_W){1'b0}}, dna_data};
            csum        <= '0;
            idx         <= '0;
            tx.tx_data  <= HDR_BYTE;
            tx.tx_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= HDR;
`ifdef DNA_CMP_EN
            dna_match   <= (dna_data == EXPECTED_DNA);
`endif
          end
        end
        HDR: begin
          if (tx.tx_ready) begin
            tx.tx_data <= frame_byte(dna_q, 3'd0);
            idx        <= '0;
            state      <= DATA;
          end
        end
        DATA: begin
          if (tx.tx_ready) begin
            csum <= csum_next;
            if (idx == 3'(FRAME_DATA_BYTES - 1)) begin
`ifdef DNA_CMP_EN
              tx.tx_data <= dna_match ? STAT_MATCH : STAT_MISMATCH;
              state      <= STAT;
`else
              tx.tx_data <= csum_next;
              state      <= CSUM;
`endif
            end else begin
              idx        <= idx + 3'd1;
              tx.tx_data <= frame_byte(dna_q, idx + 3'd1);
            end
          end
        end
        STAT: begin
          if (tx.tx_ready) begin
            csum       <= csum_next;
            tx.tx_data <= csum_next;
            state      <= CSUM;
          end
        end
        CSUM: begin
          if (tx.tx_ready) begin
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          tx.tx_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dna_frame_tx.sv
// Self-checking bench for dna_frame_tx against a byte-list frame model.
// Honours DNA_CMP_EN (status byte and dna_match) when defined.
module tb_dna_frame_tx;

  localparam logic [56:0] DNA_T1 = 57'h0123_4567_89AB_CDEF;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        dna_valid;
  logic [56:0] dna_data;
  logic        busy;
  logic        frame_done;
`ifdef DNA_CMP_EN
  logic        dna_match;
`endif

  dna_frame_tx_if tx_if ();

  dna_frame_tx #(
    .HDR_BYTE     (8'hA5)
`ifdef DNA_CMP_EN
    ,
    .EXPECTED_DNA (DNA_T1)
`endif
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .dna_valid  (dna_valid),
    .dna_data   (dna_data),
    .tx         (tx_if),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef DNA_CMP_EN
    ,
    .dna_match  (dna_match)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          fd_count = 0;
  int          first_acc = 0;
  int          last_acc = 0;
  int          ready_mode = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference frame: header, 8 big-endian bytes of the zero-extended DNA,
  // optional status, then the byte sum mod 256 of everything after the header.
  task automatic build_exp(input logic [56:0] d);
    logic [63:0] v;
    int          sum;
    v = {7'b0, d};
    sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] b;
      b = (v >> (56 - 8 * i)) & 64'hFF;
      sum += int'(b);
      exp_q.push_back(b[7:0]);
    end
`ifdef DNA_CMP_EN
    sum += (d == DNA_T1) ? 1 : 0;
    exp_q.push_back((d == DNA_T1) ? 8'h01 : 8'h00);
`endif
    exp_q.push_back(8'(sum % 256));
  endtask

  // Ready generator: 0 = always ready, 1 = toggling, 2 = random.
  always @(posedge sys_clk) begin
    #1;
    case (ready_mode)
      0:       tx_if.tx_ready = 1'b1;
      1:       tx_if.tx_ready = ~tx_if.tx_ready;
      default: tx_if.tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Stream monitor: collects accepted bytes and checks stall stability.
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(tx_if.tx_valid), 64'd1);
        check("stall_data_stable", 64'(tx_if.tx_data), 64'(prev_data));
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (rx_q.size() == 0) first_acc = cyc;
        last_acc = cyc;
        rx_q.push_back(tx_if.tx_data);
      end
      if (frame_done) begin
        fd_count++;
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("valid_low_at_done", 64'(tx_if.tx_valid), 64'd0);
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  // Produce a clean low->high dna_valid edge and check first-byte latency.
  task automatic start_frame(input logic [56:0] d);
    @(posedge sys_clk); #1;
    dna_valid = 1'b0;
    dna_data  = d;
    @(posedge sys_clk); #1;
    rx_q.delete();
    dna_valid = 1'b1;
    @(negedge sys_clk); #1;
    check("valid_low_in_trig_cycle", 64'(tx_if.tx_valid), 64'd0);
    @(negedge sys_clk); #1;
    check("valid_one_after_trig", 64'(tx_if.tx_valid), 64'd1);
    check("busy_one_after_trig", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int start_fd);
    for (int i = 0; i < 300 && fd_count == start_fd; i++) begin
      @(negedge sys_clk); #1;
    end
    check("frame_done_seen", 64'(fd_count - start_fd), 64'd1);
    repeat (3) begin
      @(negedge sys_clk); #1;
    end
    check("frame_done_once", 64'(fd_count - start_fd), 64'd1);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic compare_frame(input string tag, input logic [56:0] d);
    int n;
    build_exp(d);
    check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
`ifdef DNA_CMP_EN
    check({tag, "_match"}, 64'(dna_match), 64'(d == DNA_T1));
`endif
  endtask

  initial begin
    int          fd0;
    int          flen;
    logic [56:0] d;

    sys_rst   = 1'b1;
    dna_valid = 1'b0;
    dna_data  = '0;
    tx_if.tx_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    check("rst_tx_data", 64'(tx_if.tx_data), 64'd0);
    check("rst_tx_valid", 64'(tx_if.tx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
`ifdef DNA_CMP_EN
    check("rst_dna_match", 64'(dna_match), 64'd0);
    flen = 11;
`else
    flen = 10;
`endif
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Back-to-back frame with ready held high.
    ready_mode = 0;
    fd0 = fd_count;
    start_frame(DNA_T1);
    wait_done(fd0);
    compare_frame("t1", DNA_T1);
    check("t1_span", 64'(last_acc - first_acc + 1), 64'(flen));

    // Ready toggling every cycle: one accept every other cycle.
    ready_mode = 1;
    fd0 = fd_count;
    start_frame(DNA_T1);
    wait_done(fd0);
    compare_frame("t2", DNA_T1);
    check("t2_span", 64'(last_acc - first_acc + 1), 64'(2 * flen - 1));

    // dna_valid held high: no retrigger; a fresh pulse sends one more frame.
    ready_mode = 0;
    rx_q.delete();
    fd0 = fd_count;
    repeat (200) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    check("t3_no_retrig_bytes", 64'(rx_q.size()), 64'd0);
    check("t3_no_retrig_done", 64'(fd_count - fd0), 64'd0);
    start_frame(DNA_T1);
    wait_done(fd0);
    compare_frame("t3", DNA_T1);

    // Reset while DATA shows index 3, dna_valid kept high.
    start_frame(DNA_T1);
    for (int i = 0; i < 50 && rx_q.size() < 4; i++) begin
      @(negedge sys_clk); #1;
    end
    check("t4_reached_idx3", 64'(rx_q.size()), 64'd4);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk); #1;
    check("t4_valid_after_rst", 64'(tx_if.tx_valid), 64'd0);
    check("t4_busy_after_rst", 64'(busy), 64'd0);
    rx_q.delete();
    fd0 = fd_count;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    wait_done(fd0);
    compare_frame("t4", DNA_T1);

    // All-ones DNA: checksum wraps.
    fd0 = fd_count;
    start_frame({57{1'b1}});
    wait_done(fd0);
    compare_frame("t6", {57{1'b1}});

    // DNA one bit away from the reference.
    fd0 = fd_count;
    start_frame(DNA_T1 ^ 57'h1);
    wait_done(fd0);
    compare_frame("t5", DNA_T1 ^ 57'h1);

    // Random DNA and ready patterns; dna_valid sometimes drops mid-frame
    // with dna_data scrambled, which must not alter the frame.
    for (int k = 0; k < 12; k++) begin
      d = {$urandom, $urandom};
      if (k == 3) d = DNA_T1;
      ready_mode = int'($urandom_range(0, 2));
      fd0 = fd_count;
      start_frame(d);
      repeat ($urandom_range(0, 6)) @(posedge sys_clk);
      if ($urandom_range(0, 1) == 1) begin
        #1;
        dna_valid = 1'b0;
        dna_data  = {$urandom, $urandom};
      end
      wait_done(fd0);
      compare_frame($sformatf("rnd%0d", k), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
